// File: rtl/aoi_pkg.sv
// aoi_pkg: shared declarations for the pipelined AND-OR-INVERT evaluator.
//   sweep_state_t : self-sweep controller states
//   DRAIN_CYCLES  : cycles spent in DRAIN while the last sweep results retire
//   aoi_ref()     : reference AOI evaluation for benches (not used by RTL)
package aoi_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } sweep_state_t;

  localparam int DRAIN_CYCLES = 2;

  // Reference result: y = ~(OR over enabled groups of AND over group bits).
  // Widths are generous so any practical GROUPS/GWIDTH fits.
  function automatic logic aoi_ref(input logic [63:0] a,
                                   input logic [63:0] mask,
                                   input int          groups,
                                   input int          gwidth);
    logic all_set;
    for (int g = 0; g < groups; g++) begin
      all_set = 1'b1;
      for (int b = 0; b < gwidth; b++) begin
        if (!a[g*gwidth + b]) all_set = 1'b0;
      end
      if (mask[g] && all_set) return 1'b0;
    end
    return 1'b1;
  endfunction

endpackage

// File: rtl/aoi_pipe_array_if.sv
// aoi_pipe_array_if: streaming bus of the AOI evaluator.
//   in_valid/in_ready : input handshake, a + group_mask travel with it
//   out_valid/out_ready : output handshake, y travels with it
// Modports: master = stream source/sink (bench side), slave = evaluator side.
interface aoi_pipe_array_if #(
  parameter int GROUPS = 5,
  parameter int GWIDTH = 2
);
  logic                       in_valid;
  logic                       in_ready;
  logic [GROUPS*GWIDTH-1:0]   a;
  logic [GROUPS-1:0]          group_mask;
  logic                       out_valid;
  logic                       out_ready;
  logic                       y;

  modport master (
    output in_valid, a, group_mask, out_ready,
    input  in_ready, out_valid, y
  );

  modport slave (
    input  in_valid, a, group_mask, out_ready,
    output in_ready, out_valid, y
  );
endinterface

// File: rtl/aoi_term_stage.sv
// aoi_term_stage: stage 1 of the AOI pipeline.
// Computes the masked per-group AND terms and registers them with a valid bit.
//   clk, rst   : clock, synchronous active-high reset
//   en         : stage advance; when low the register holds
//   load_valid : the word on a/mask is real data this cycle
//   a, mask    : input bits and per-group enables
//   terms      : registered masked AND terms (one per group)
//   valid      : registered valid
module aoi_term_stage #(
  parameter int GROUPS = 5,
  parameter int GWIDTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     load_valid,
  input  logic [GROUPS*GWIDTH-1:0] a,
  input  logic [GROUPS-1:0]        mask,
  output logic [GROUPS-1:0]        terms,
  output logic                     valid
);

  logic [GROUPS-1:0] terms_next;
  logic [GROUPS-1:0] terms_reg;
  logic              valid_reg;

  // A disabled group contributes a 0 AND term, so it can never pull y low.
  generate
    for (genvar gi = 0; gi < GROUPS; gi++) begin : g_term
      assign terms_next[gi] = mask[gi] & (&a[gi*GWIDTH +: GWIDTH]);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      terms_reg <= '0;
      valid_reg <= 1'b0;
    end else if (en) begin
      valid_reg <= load_valid;
      if (load_valid) terms_reg <= terms_next;
    end
  end

  assign terms = terms_reg;
  assign valid = valid_reg;

endmodule

// File: rtl/aoi_pipe_array.sv
// aoi_pipe_array: two-stage pipelined AND-OR-INVERT evaluator,
// y = ~(OR over groups of AND over each group's GWIDTH bits), with a
// per-group enable mask and valid/ready streaming.
//   clk, rst    : clock, synchronous active-high reset
//   bus (slave) : in_valid/in_ready/a/group_mask, out_valid/out_ready/y
//   sweep_start : request an exhaustive on-chip sweep of all 2^N patterns
//   sweep_busy  : sweep in RUN or DRAIN
//   sweep_done  : one-cycle pulse after the sweep completes
//   ones_count  : number of patterns with y=1 in the last sweep
// Build option: AOI_SWEEP_EN builds the sweep controller, pattern counter
// and ones counter. Without it the sweep outputs are tied to 0 and
// sweep_start is ignored; the streaming path is identical.
module aoi_pipe_array
  import aoi_pkg::*;
#(
  parameter int GROUPS = 5,
  parameter int GWIDTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  aoi_pipe_array_if.slave        bus,
  input  logic                   sweep_start,
  output logic                   sweep_busy,
  output logic                   sweep_done,
  output logic [GROUPS*GWIDTH:0] ones_count
);

  localparam int N = GROUPS * GWIDTH;

  logic              advance;
  logic              accept;
  logic              sweep_go;     // sweep start accepted this cycle
  logic              run_feed;     // sweep owns the stage-1 input this cycle
  logic [N-1:0]      feed_a;
  logic [GROUPS-1:0] feed_mask;
  logic              s1_sweep;     // stage-1 word came from the sweep

  logic [N-1:0]      s1_a;
  logic [GROUPS-1:0] s1_mask;
  logic              s1_load_valid;
  logic [GROUPS-1:0] terms;
  logic              s1_valid;

  logic              out_valid_reg;
  logic              y_reg;

  // Both stages move together; a stalled output freezes the whole pipe.
  assign advance      = ~out_valid_reg | bus.out_ready;
  // A sweep start wins over an input offered in the same cycle.
  assign bus.in_ready = advance & ~sweep_busy & ~rst & ~sweep_go;
  assign accept       = bus.in_valid & bus.in_ready;

  // Stage-1 input mux: sweep patterns or external words.
  assign s1_a          = run_feed ? feed_a    : bus.a;
  assign s1_mask       = run_feed ? feed_mask : bus.group_mask;
  assign s1_load_valid = run_feed | accept;

  aoi_term_stage #(
    .GROUPS (GROUPS),
    .GWIDTH (GWIDTH)
  ) u_term_stage (
    .clk        (clk),
    .rst        (rst),
    .en         (advance),
    .load_valid (s1_load_valid),
    .a          (s1_a),
    .mask       (s1_mask),
    .terms      (terms),
    .valid      (s1_valid)
  );

  // Stage 2 (streaming): only external words reach out_valid/y, so sweep
  // traffic never appears on the output handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_reg <= 1'b0;
      y_reg         <= 1'b0;
    end else if (advance) begin
      out_valid_reg <= s1_valid & ~s1_sweep;
      if (s1_valid & ~s1_sweep) y_reg <= ~|terms;
    end
  end

  assign bus.out_valid = out_valid_reg;
  assign bus.y         = y_reg;

`ifdef AOI_SWEEP_EN

  sweep_state_t      state_reg, state_next;
  logic [N-1:0]      pattern_reg, pattern_next;
  logic [GROUPS-1:0] mask_reg, mask_next;
  logic [N:0]        ones_reg, ones_next;
  logic [1:0]        drain_reg, drain_next;
  logic              s1_sweep_reg;
  logic              s2_sweep_valid_reg;
  logic              s2_sweep_y_reg;
  logic              done_reg;
  logic              pipe_empty;

  // A sweep may only start once no streaming or sweep word is in flight.
  assign pipe_empty = ~s1_valid & ~out_valid_reg & ~s2_sweep_valid_reg;

  always_comb begin
    state_next   = state_reg;
    pattern_next = pattern_reg;
    mask_next    = mask_reg;
    ones_next    = ones_reg;
    drain_next   = drain_reg;
    sweep_go     = 1'b0;
    run_feed     = 1'b0;

    // Count each retired sweep result with y=1. Cannot overflow: at most
    // 2^N results and the counter is N+1 bits.
    if (s2_sweep_valid_reg && s2_sweep_y_reg) ones_next = ones_reg + 1'b1;

    case (state_reg)
      IDLE: begin
        if (sweep_start && pipe_empty && !rst) begin
          sweep_go     = 1'b1;
          state_next   = RUN;
          pattern_next = '0;
          mask_next    = bus.group_mask;
          ones_next    = '0;
        end
      end
      RUN: begin
        run_feed     = 1'b1;
        pattern_next = pattern_reg + 1'b1;
        if (pattern_reg == '1) begin
          state_next = DRAIN;
          drain_next = '0;
        end
      end
      DRAIN: begin
        if (drain_reg == 2'(DRAIN_CYCLES - 1)) state_next = DONE;
        else                                   drain_next = drain_reg + 1'b1;
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg          <= IDLE;
      pattern_reg        <= '0;
      mask_reg           <= '0;
      ones_reg           <= '0;
      drain_reg          <= '0;
      s1_sweep_reg       <= 1'b0;
      s2_sweep_valid_reg <= 1'b0;
      s2_sweep_y_reg     <= 1'b0;
      done_reg           <= 1'b0;
    end else begin
      state_reg   <= state_next;
      pattern_reg <= pattern_next;
      mask_reg    <= mask_next;
      ones_reg    <= ones_next;
      drain_reg   <= drain_next;
      // Registered so the pulse lands after the last result has been counted.
      done_reg    <= (state_reg == DONE);
      if (advance) begin
        s1_sweep_reg       <= run_feed;
        s2_sweep_valid_reg <= s1_valid & s1_sweep_reg;
        s2_sweep_y_reg     <= ~|terms;
      end
    end
  end

  assign feed_a     = pattern_reg;
  assign feed_mask  = mask_reg;
  assign s1_sweep   = s1_sweep_reg;
  assign sweep_busy = (state_reg == RUN) || (state_reg == DRAIN);
  assign sweep_done = done_reg;
  assign ones_count = ones_reg;

`else

  logic unused_sweep_start;

  assign unused_sweep_start = sweep_start;
  assign sweep_go           = 1'b0;
  assign run_feed           = 1'b0;
  assign feed_a             = '0;
  assign feed_mask          = '0;
  assign s1_sweep           = 1'b0;
  assign sweep_busy         = 1'b0;
  assign sweep_done         = 1'b0;
  assign ones_count         = '0;

`endif

endmodule

// File: tb/tb_aoi_pipe_array.sv
// tb_aoi_pipe_array: directed bench for aoi_pipe_array (GROUPS=5, GWIDTH=2).
// A group-level behavioural model predicts y for every accepted word; one
// compare process checks every output transfer in order. Literal
// expectations pin the model and the DUT for the directed vectors.
// Sweep checks are built when AOI_SWEEP_EN is defined.
module tb_aoi_pipe_array;
  import aoi_pkg::*;

  localparam int GR = 5;
  localparam int GW = 2;
  localparam int NB = GR * GW;

  logic          clk;
  logic          rst;
  logic          sweep_start;
  logic          sweep_busy;
  logic          sweep_done;
  logic [NB:0]   ones_count;

  aoi_pipe_array_if #(.GROUPS(GR), .GWIDTH(GW)) bus ();

  aoi_pipe_array #(
    .GROUPS (GR),
    .GWIDTH (GW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .sweep_start (sweep_start),
    .sweep_busy  (sweep_busy),
    .sweep_done  (sweep_done),
    .ones_count  (ones_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_cmp  = 0;
  int   n_fail = 0;
  int   cyc    = 0;
  logic exp_q[$];
  logic got_q[$];
  int   got_cyc[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // y is 0 exactly when some enabled group has every one of its bits set.
  function automatic logic model_y(input logic [NB-1:0] av, input logic [GR-1:0] mv);
    int unsigned v;
    int unsigned full;
    v    = av;
    full = (1 << GW) - 1;
    for (int g = 0; g < GR; g++) begin
      if (mv[g] && (((v >> (g * GW)) & full) == full)) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic int model_ones(input logic [GR-1:0] mv);
    int cnt;
    cnt = 0;
    for (int p = 0; p < (1 << NB); p++) begin
      if (model_y(NB'(p), mv)) cnt++;
    end
    return cnt;
  endfunction

  // Compare process: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      exp_q.delete();
    end else begin
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output", 1, 0);
        end else begin
          logic e;
          e = exp_q.pop_front();
          $display("txn cyc %0d: y=%0d expected=%0d", cyc, bus.y, e);
          check("y_stream", bus.y, e);
        end
        got_q.push_back(bus.y);
        got_cyc.push_back(cyc);
      end
      if (bus.in_valid && bus.in_ready) exp_q.push_back(model_y(bus.a, bus.group_mask));
      if (sweep_busy) check("out_valid_quiet_in_sweep", bus.out_valid, 0);
    end
  end

  // Offer one word and wait (bounded) for it to be accepted.
  task automatic send(input logic [NB-1:0] av, input logic [GR-1:0] mv);
    bit ok;
    ok = 1'b0;
    bus.in_valid   = 1'b1;
    bus.a          = av;
    bus.group_mask = mv;
    for (int k = 0; k < 50 && !ok; k++) begin
      @(negedge clk);
      ok = bus.in_ready;
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    check("send_accepted", ok, 1);
  endtask

  task automatic wait_outputs(input int n);
    for (int k = 0; k < 30 && got_q.size() < n; k++) @(posedge clk);
    #1;
    check("output_count", got_q.size(), n);
  endtask

`ifdef AOI_SWEEP_EN
  // Called just after a rising edge with an empty pipeline.
  task automatic run_sweep(input logic [GR-1:0] mv, input int exp_ones, input bit poke_busy);
    int done_at;
    int quiet_bad;
    sweep_start    = 1'b1;
    bus.group_mask = mv;
    bus.in_valid   = 1'b1;
    bus.a          = '0;
    @(negedge clk);
    check("sweep_wins_in_ready", bus.in_ready, 0);
    @(posedge clk);            // edge S samples sweep_start
    #1;
    sweep_start  = 1'b0;
    bus.in_valid = 1'b0;
    done_at      = -1;
    quiet_bad    = 0;
    for (int k = 1; k <= 1040; k++) begin
      @(negedge clk);          // cycle following edge S+k
      if (k == 1) check("sweep_busy_set", sweep_busy, 1);
      if (sweep_done && done_at < 0) done_at = k;
      if (bus.out_valid) quiet_bad++;
      if (k == (1 << NB) + 4) check("sweep_done_one_cycle", sweep_done, 0);
      @(posedge clk);
      #1;
      sweep_start = (poke_busy && k == 10);
    end
    sweep_start = 1'b0;
    check("sweep_done_edge", done_at, (1 << NB) + 3);
    check("sweep_ones", ones_count, exp_ones);
    check("sweep_out_valid_quiet", quiet_bad, 0);
    check("sweep_busy_clear", sweep_busy, 0);
  endtask
`endif

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic exp_fn[6];
    logic exp_bp[3];

    // Model pins against hand-computed values.
    check("pin_model_060",   model_y(10'h060, 5'h1F), 1);
    check("pin_model_0C0",   model_y(10'h0C0, 5'h1F), 0);
    check("pin_model_mask",  model_y(10'h003, 5'b11110), 1);
    check("pin_ref_0C0",     aoi_ref(64'h0C0, 64'h1F, GR, GW), 0);
    check("pin_ones_1F",     model_ones(5'h1F), 243);
    check("pin_ones_01",     model_ones(5'b00001), 768);

    // Reset with in_valid held high.
    rst            = 1'b1;
    sweep_start    = 1'b0;
    bus.in_valid   = 1'b1;
    bus.a          = 10'h060;
    bus.group_mask = 5'h1F;
    bus.out_ready  = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("in_ready_in_reset", bus.in_ready, 0);
    end
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_y", bus.y, 0);
    check("rst_sweep_busy", sweep_busy, 0);
    check("rst_sweep_done", sweep_done, 0);
    check("rst_ones", ones_count, 0);
    @(posedge clk);
    #1;
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    check("post_rst_out_valid", bus.out_valid, 0);
    check("post_rst_y", bus.y, 0);

    // Latency: the accepting edge loads stage 1, the next loads stage 2.
    @(posedge clk);
    #1;
    bus.in_valid = 1'b1;
    bus.a        = 10'h060;
    @(negedge clk);
    check("first_in_ready", bus.in_ready, 1);
    @(posedge clk);            // accepting edge
    #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("lat_after_accept_edge", bus.out_valid, 0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("lat_after_second_edge", bus.out_valid, 1);
    check("lat_y", bus.y, 1);
    @(posedge clk);
    #1;

    // Function and mask vectors, back to back.
    got_q.delete();
    got_cyc.delete();
    send(10'h060, 5'h1F);
    send(10'h0C0, 5'h1F);
    send(10'h000, 5'h1F);
    send(10'h3FF, 5'h1F);
    send(10'h003, 5'b11110);
    send(10'h003, 5'b00001);
    wait_outputs(6);
    exp_fn = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 6 && i < got_q.size(); i++) check("fn_literal", got_q[i], exp_fn[i]);

    // Backpressure.
    got_q.delete();
    got_cyc.delete();
    bus.out_ready = 1'b0;
    send(10'h0C0, 5'h1F);
    send(10'h060, 5'h1F);
    bus.in_valid = 1'b1;
    bus.a        = 10'h3FF;
    repeat (5) begin
      @(negedge clk);
      check("stall_in_ready", bus.in_ready, 0);
      check("stall_out_valid", bus.out_valid, 1);
      check("stall_y_held", bus.y, 0);
      @(posedge clk);
      #1;
    end
    bus.out_ready = 1'b1;
    send(10'h3FF, 5'h1F);
    wait_outputs(3);
    exp_bp = '{1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 3 && i < got_q.size(); i++) check("bp_literal", got_q[i], exp_bp[i]);
    if (got_cyc.size() >= 3) begin
      check("bp_no_gap_1", got_cyc[1] - got_cyc[0], 1);
      check("bp_no_gap_2", got_cyc[2] - got_cyc[1], 1);
    end
    repeat (4) @(posedge clk);
    #1;

`ifdef AOI_SWEEP_EN
    run_sweep(5'h1F, model_ones(5'h1F), 1'b1);
    repeat (3) @(posedge clk);
    #1;
    run_sweep(5'b00001, model_ones(5'b00001), 1'b0);
    repeat (3) @(posedge clk);
    #1;

    // Reset mid-sweep, with a sweep_start in the reset cycle.
    sweep_start    = 1'b1;
    bus.group_mask = 5'h1F;
    @(posedge clk);
    #1;
    sweep_start = 1'b0;
    repeat (499) @(posedge clk);
    #1;
    @(negedge clk);
    check("mid_sweep_busy", sweep_busy, 1);
    @(posedge clk);
    #1;
    rst         = 1'b1;
    sweep_start = 1'b1;
    @(posedge clk);
    #1;
    rst         = 1'b0;
    sweep_start = 1'b0;
    @(negedge clk);
    check("rst_sweep_busy_cleared", sweep_busy, 0);
    check("rst_ones_cleared", ones_count, 0);
    check("rst_done_cleared", sweep_done, 0);
    check("rst_out_valid_cleared", bus.out_valid, 0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("start_with_rst_ignored", sweep_busy, 0);
    @(posedge clk);
    #1;
    run_sweep(5'h1F, 243, 1'b0);
`else
    sweep_start  = 1'b1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("nosweep_in_ready", bus.in_ready, 1);
    @(posedge clk);
    #1;
    sweep_start = 1'b0;
    @(negedge clk);
    check("nosweep_busy", sweep_busy, 0);
    check("nosweep_done", sweep_done, 0);
    check("nosweep_ones", ones_count, 0);
    @(posedge clk);
    #1;
`endif

    // Every accepted word has come out.
    for (int k = 0; k < 20 && exp_q.size() != 0; k++) @(posedge clk);
    #1;
    check("scoreboard_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
